serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/serial_fs_cell.sv | 13 +
 rtl/serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder and subtractor):
// FSM state encoding and the default operand width.
package serial_arith_pkg;

  localparam int SERIAL_DEFAULT_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } serial_state_e;

endpackage

// File: rtl/serial_fs_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module serial_fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = A - B, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     diff,
  output logic                 borrow,
  output logic                 busy,
  output logic                 done,
`ifdef SERIAL_SUB_OVF_EN
  output logic                 ovf,
`endif
  output serial_state_e        dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: start is a request seen only in IDLE; the edge that sees it is
  // the accepting edge, A/B are captured there, and done pulses WIDTH edges later.
  serial_state_e state, next_state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt;
  logic             bin_q;
  logic             accept, last_bit;
  logic             cell_d, cell_bout;

  serial_fs_cell u_cell (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        last_bit = (cnt == LAST);
        if (last_bit) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state == RUN);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      bin_q  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      done   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_q    <= A;
        b_q    <= B;
        cnt    <= '0;
        bin_q  <= 1'b0;
        diff   <= '0;
        borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf    <= 1'b0;
`endif
      end else if (state == RUN) begin
        diff[cnt] <= cell_d;
        bin_q     <= cell_bout;
        cnt       <= cnt + CW'(1);
        if (last_bit) begin
          borrow <= cell_bout;
          done   <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // The MSB of the result is the bit being produced this cycle.
          ovf    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d != a_q[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule
